// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit countdown timer, one-shot/auto-reload IRQ; prescaler only when TIMER_PRESCALE_EN is defined.
// Reads are a zero-latency mux, writes land on the WE edge, IRQ is registered; no backpressure (always ready).
module timer_dev #(
  parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_PSC    = 2'd3;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pend;
  logic        tick;
  logic [31:0] psc_rd;

  logic ctrl_we;
  logic preset_we;
  logic auto_mode;

  assign ctrl_we   = WE && (Addr == ADDR_CTRL);
  assign preset_we = WE && (Addr == ADDR_PRESET);
  assign auto_mode = (mode == 2'b01);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] psc;
  logic [7:0] psc_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      psc     <= 8'd0;
      psc_cnt <= 8'd0;
    end else begin
      if (WE && (Addr == ADDR_PSC))
        psc <= Din[7:0];
      // The divider only runs while counting; any other state restarts it.
      if (state == CNT)
        psc_cnt <= (psc_cnt == psc) ? 8'd0 : psc_cnt + 8'd1;
      else
        psc_cnt <= 8'd0;
    end
  end

  assign tick   = (state == CNT) && (psc_cnt == psc);
  assign psc_rd = {24'd0, psc};
`else
  assign tick   = (state == CNT);
  assign psc_rd = 32'd0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'b00;
      im       <= 1'b0;
      preset   <= PRESET_RST;
      count    <= 32'd0;
      irq_pend <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (preset_we)
        preset <= Din;
      if (ctrl_we) begin
        en       <= Din[0];
        mode     <= Din[2:1];
        im       <= Din[3];
        irq_pend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (en)
            state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count    <= 32'd0;
              irq_pend <= 1'b1;
              state    <= INT;
            end
          end
        end
        INT: begin
          if (auto_mode) begin
            irq_pend <= 1'b0;
            state    <= LOAD;
          end else begin
            // A CTRL write on this same edge keeps its own Enable value.
            if (!ctrl_we)
              en <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      IRQ <= irq_pend & im;
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      ADDR_CTRL:   Dout = {28'd0, im, mode, en};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      ADDR_PSC:    Dout = psc_rd;
      default:     Dout = 32'd0;
    endcase
  end

endmodule
